// File: rtl/adder_share_arb_if.sv
// rtl/adder_share_arb_if.sv - requester, result and shared-adder signals of adder_share_arb
// The slave modport is the arbiter; the master modport is the requesters plus external adder.
interface adder_share_arb_if #(
    parameter int WIDTH = 7
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] opa0;
    logic [WIDTH-1:0] opb0;
    logic [WIDTH-1:0] opa1;
    logic [WIDTH-1:0] opb1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [WIDTH:0]   res;
    logic             owner;
    logic             busy;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    modport slave (
        input  req0, req1, opa0, opb0, opa1, opb1, add_sum, add_cout,
        output ack0, ack1, done0, done1, res, owner, busy, add_x, add_y, add_cin
    );

    modport master (
        output req0, req1, opa0, opb0, opa1, opb1, add_sum, add_cout,
        input  ack0, ack1, done0, done1, res, owner, busy, add_x, add_y, add_cin
    );
endinterface

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin sharing of one external ripple adder between two requesters
// Operands are latched on the grant edge and the adder output is captured SETTLE cycles later.
module adder_share_arb #(
    parameter int WIDTH  = 7,
    parameter int SETTLE = 2
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    adder_share_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] L_SETTLE = 4'(SETTLE);

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_cur;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_add_x;
    logic [WIDTH-1:0] r_add_y;
    logic [WIDTH:0]   r_res;
    logic             r_owner;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_done0;
    logic             r_done1;
    logic             r_busy;
    logic             w_grant;
    logic             w_win;
    logic             w_capture;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req0 || bus.req1) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // A lone request wins outright; a tie goes to the requester named by r_ptr.
    always_comb begin
        w_grant   = (r_state == S_IDLE) && (bus.req0 || bus.req1);
        w_win     = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
        w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd1);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_ptr   <= 1'b0;
            r_cur   <= 1'b0;
            r_cnt   <= 4'd0;
            r_add_x <= '0;
            r_add_y <= '0;
            r_res   <= '0;
            r_owner <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= (w_next != S_IDLE);
            if (w_grant) begin
                r_add_x <= w_win ? bus.opa1 : bus.opa0;
                r_add_y <= w_win ? bus.opb1 : bus.opb0;
                r_ack0  <= ~w_win;
                r_ack1  <= w_win;
                r_cur   <= w_win;
                r_cnt   <= L_SETTLE;
                r_ptr   <= ~w_win;
            end else if (r_state == S_SETTLE) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_res   <= {bus.add_cout, bus.add_sum};
                r_owner <= r_cur;
                r_done0 <= ~r_cur;
                r_done1 <= r_cur;
            end
        end
    end

    assign bus.add_x   = r_add_x;
    assign bus.add_y   = r_add_y;
    assign bus.add_cin = 1'b0;
    assign bus.res     = r_res;
    assign bus.owner   = r_owner;
    assign bus.ack0    = r_ack0;
    assign bus.ack1    = r_ack1;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - scoreboard bench for adder_share_arb with a slow external adder model
// Expected results are queued as requests are driven and retired on each done pulse.
module tb_adder_share_arb;
    localparam int W = 7;
    parameter int SETTLE = 2;

    typedef struct {
        bit         who;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ack = 0;
    bit   have_prev = 1'b0;
    bit   spacing_en = 1'b0;
    bit   exp_ptr = 1'b0;
    exp_t sb[$];
    bit   gq[$];

    adder_share_arb_if #(.WIDTH(W)) bus ();

    adder_share_arb #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // External adder: garbage output for a random 0..SETTLE-1 cycles after its inputs move.
    logic [2*W-1:0] m_last = '1;
    int             m_cnt = 0;
    always @(negedge clk) begin
        logic [W:0] s;
        s = {1'b0, bus.add_x} + {1'b0, bus.add_y};
        if ({bus.add_x, bus.add_y} != m_last) begin
            m_last = {bus.add_x, bus.add_y};
            m_cnt  = int'($urandom_range(SETTLE - 1, 0));
            {bus.add_cout, bus.add_sum} = (m_cnt == 0) ? s : ~s;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) {bus.add_cout, bus.add_sum} = s;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack0 | bus.ack1 | bus.done0 | bus.done1) begin
                chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 0);
                chk("done_onehot", 32'(bus.done0 & bus.done1), 0);
                chk("ack_done_same", 32'((bus.ack0 & bus.done0) | (bus.ack1 & bus.done1)), 0);
            end
            if (bus.ack0 | bus.ack1) begin
                if (gq.size() == 0) chk("unexpected_ack", 1, 0);
                else chk("grant_who", 32'(bus.ack1), 32'(gq.pop_front()));
                chk("busy_on_ack", 32'(bus.busy), 1);
                if (spacing_en && have_prev) chk("grant_spacing", cyc - last_ack, SETTLE + 2);
                have_prev = 1'b1;
                last_ack  = cyc;
            end
            if (bus.done0 | bus.done1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("owner", 32'(bus.owner), 32'(e.who));
                    chk("done_who", 32'(bus.done1), 32'(e.who));
                    chk("res", 32'(bus.res), 32'(e.res));
                    chk("add_x_held", 32'(bus.add_x), 32'(e.x));
                    chk("add_y_held", 32'(bus.add_y), 32'(e.y));
                    chk("latency", cyc - last_ack + 1, SETTLE + 1);
                end
            end
        end
    end

    function automatic exp_t mk(input bit who, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.who = who;
        e.x   = a;
        e.y   = b;
        e.res = {1'b0, a} + {1'b0, b};
        return e;
    endfunction

    task automatic set_ops(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        if (who) begin bus.opa1 = a; bus.opb1 = b; bus.req1 = r; end
        else     begin bus.opa0 = a; bus.opb0 = b; bus.req0 = r; end
    endtask

    task automatic wait_ack(input bit who);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); #1;
            if (who ? bus.ack1 : bus.ack0) ok = 1'b1;
        end
        if (!ok) chk("ack_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !bus.busy) ok = 1'b1;
        end
        if (!ok) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
            gq.delete();
        end
    endtask

    task automatic do_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b);
        sb.push_back(mk(who, a, b));
        gq.push_back(who);
        exp_ptr = ~who;
        set_ops(who, a, b, 1'b1);
        wait_ack(who);
        set_ops(who, ~a, ~b, 1'b0);
        wait_drain();
    endtask

    // Both requesters hold requests for n operations each; grants must alternate from exp_ptr.
    task automatic run_pair(input int n);
        logic [W-1:0] pa[2][4];
        logic [W-1:0] pb[2][4];
        int           pc[2];
        int           idx[2];
        bit           w;
        logic [31:0]  t;
        w = exp_ptr;
        for (int r = 0; r < 2; r++) begin
            pc[r] = 0;
            idx[r] = 0;
            for (int i = 0; i < n; i++) begin
                t = $urandom; pa[r][i] = t[W-1:0];
                t = $urandom; pb[r][i] = t[W-1:0];
            end
        end
        for (int k = 0; k < 2 * n; k++) begin
            bit who;
            who = w ^ k[0];
            sb.push_back(mk(who, pa[who][pc[who]], pb[who][pc[who]]));
            gq.push_back(who);
            pc[who]++;
        end
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        set_ops(1'b0, pa[0][0], pb[0][0], 1'b1);
        set_ops(1'b1, pa[1][0], pb[1][0], 1'b1);
        for (int k = 0; k < 2 * n; k++) begin
            bit ok = 1'b0;
            bit who;
            for (int i = 0; i < 60 && !ok; i++) begin
                @(negedge clk); #1;
                if (bus.ack0 | bus.ack1) ok = 1'b1;
            end
            if (!ok) begin
                chk("pair_ack_timeout", 1, 0);
                break;
            end
            who = bus.ack1;
            idx[who]++;
            if (idx[who] < n) set_ops(who, pa[who][idx[who]], pb[who][idx[who]], 1'b1);
            else              set_ops(who, ~pa[who][0], ~pb[who][0], 1'b0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_drain();
        spacing_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.opa0 = '0; bus.opb0 = '0; bus.opa1 = '0; bus.opb1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ack", 32'({bus.ack0, bus.ack1}), 0);
        chk("rst_done", 32'({bus.done0, bus.done1}), 0);
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_add_xy", 32'({bus.add_x, bus.add_y}), 0);
        chk("add_cin", 32'(bus.add_cin), 0);
        rst = 1'b0;

        do_op(1'b0, 7'd100, 7'd27);
        do_op(1'b1, 7'd127, 7'd127);
        do_op(1'b0, 7'd0, 7'd0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_ptr = 1'b0;
        run_pair(2);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            t = $urandom; a = t[W-1:0];
            t = $urandom; b = t[W-1:0];
            do_op(t[20], a, b);
        end

        do_op(1'b1, 7'd55, 7'd66);
        sb.push_back(mk(1'b0, 7'd9, 7'd10));
        gq.push_back(1'b0);
        set_ops(1'b0, 7'd9, 7'd10, 1'b1);
        wait_ack(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ack", 32'({bus.ack0, bus.ack1}), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_res", 32'(bus.res), 0);
        chk("midrst_add_xy", 32'({bus.add_x, bus.add_y}), 0);
        chk("midrst_owner", 32'(bus.owner), 0);
        sb.delete();
        gq.delete();
        bus.req0 = 1'b0;
        for (int i = 0; i < SETTLE + 2; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'({bus.done0, bus.done1}), 0);
        end
        rst = 1'b0;
        exp_ptr = 1'b0;
        run_pair(1);
        run_pair(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
